// File: rtl/ir_filter_pkg.sv
// Shared types and window geometry for the IR obstacle filter.
package ir_filter_pkg;

  localparam int unsigned WIN_DEPTH = 8;
  localparam int unsigned WIN_LOG2  = 3;
  localparam int unsigned SUM_W     = 11;

  typedef enum logic [2:0] {
    StClear,
    StNearPend,
    StBlocked,
    StFarPend,
    StStale
  } filt_state_e;

endpackage

// File: rtl/dist_window_avg.sv
// 8-sample moving average of the raw IR distance stream.
// flush restarts the window so the current sample becomes its first entry.
module dist_window_avg
  import ir_filter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic [7:0] dist_in,
  input  logic       dist_valid,
  output logic [7:0] dist_avg,
  output logic       avg_valid
);

  localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2 + 1)'(WIN_DEPTH);
  localparam logic [WIN_LOG2:0] FILL_LAST = FILL_FULL - 1'b1;

  logic [7:0]          win_q [WIN_DEPTH];
  logic [WIN_LOG2-1:0] ptr_q;
  logic [WIN_LOG2:0]   fill_q;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;
  logic [7:0]          oldest;
  logic                win_full;

  // Running sum: add new sample, drop the one leaving the window (none until full).
  always_comb begin
    win_full = (fill_q == FILL_FULL);
    oldest   = win_full ? win_q[ptr_q] : 8'd0;
    sum_d    = sum_q + SUM_W'(dist_in) - SUM_W'(oldest);
  end

  // Window storage, pointer, fill count and registered average.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIN_DEPTH; i++) win_q[i] <= 8'd0;
      ptr_q     <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      dist_avg  <= 8'd0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (dist_valid) begin
        if (flush) begin
          win_q[0] <= dist_in;
          ptr_q    <= WIN_LOG2'(1);
          fill_q   <= (WIN_LOG2 + 1)'(1);
          sum_q    <= SUM_W'(dist_in);
        end else begin
          win_q[ptr_q] <= dist_in;
          ptr_q        <= ptr_q + 1'b1;
          sum_q        <= sum_d;
          if (!win_full) fill_q <= fill_q + 1'b1;
          // Average is meaningful once this sample completes the window.
          if (fill_q >= FILL_LAST) begin
            avg_valid <= 1'b1;
            dist_avg  <= sum_d[SUM_W-1:SUM_W-8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ir_obstacle_filter.sv
// Debounced obstacle detector on top of a moving-average IR distance window,
// with sensor-timeout detection and a sticky processor interrupt.
module ir_obstacle_filter
  import ir_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE    = 3,
  parameter int unsigned TIMEOUT_CYC = 131000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dist_in,
  input  logic       dist_valid,
  input  logic [7:0] thr_near,
  input  logic [7:0] thr_far,
  input  logic       irq_clr,
  output logic [7:0] dist_avg,
  output logic       avg_valid,
  output logic       obstacle,
  output logic       stale,
  output logic       irq
);

  localparam logic [19:0] TMO_MAX = 20'(TIMEOUT_CYC);
  localparam logic [3:0]  DEB_MAX = 4'(DEBOUNCE);

  filt_state_e state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_inc;
  logic [19:0] tmo_q;
  logic        tmo_hit;
  logic        avg_le_near;
  logic        avg_ge_far;
  logic        flush;

  dist_window_avg u_window (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .dist_avg   (dist_avg),
    .avg_valid  (avg_valid)
  );

  // Decision terms for the FSM; thresholds are taken live in the avg_valid cycle.
  always_comb begin
    flush       = (state_q == StStale);
    cnt_inc     = cnt_q + 4'd1;
    tmo_hit     = !dist_valid && (tmo_q == TMO_MAX - 20'd1);
    avg_le_near = (dist_avg <= thr_near);
    avg_ge_far  = (dist_avg >= thr_far);
  end

  // Cycles since the last sample, saturating at the timeout.
  always_ff @(posedge clk) begin
    if (rst || dist_valid) tmo_q <= '0;
    else if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 20'd1;
  end

  // Obstacle FSM with registered flags; a same-cycle set of irq beats irq_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StClear;
      cnt_q    <= '0;
      obstacle <= 1'b0;
      stale    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (irq_clr) irq <= 1'b0;
      if (tmo_hit && state_q != StStale) begin
        state_q  <= StStale;
        cnt_q    <= '0;
        obstacle <= 1'b1;
        stale    <= 1'b1;
        irq      <= 1'b1;
      end else begin
        case (state_q)
          StClear, StNearPend: begin
            if (avg_valid) begin
              if (!avg_le_near) begin
                state_q <= StClear;
                cnt_q   <= '0;
              end else if (cnt_inc >= DEB_MAX) begin
                state_q  <= StBlocked;
                cnt_q    <= '0;
                obstacle <= 1'b1;
                irq      <= 1'b1;
              end else begin
                state_q <= StNearPend;
                cnt_q   <= cnt_inc;
              end
            end
          end
          StBlocked, StFarPend: begin
            if (avg_valid) begin
              if (!avg_ge_far) begin
                state_q <= StBlocked;
                cnt_q   <= '0;
              end else if (cnt_inc >= DEB_MAX) begin
                state_q  <= StClear;
                cnt_q    <= '0;
                obstacle <= 1'b0;
              end else begin
                state_q <= StFarPend;
                cnt_q   <= cnt_inc;
              end
            end
          end
          StStale: begin
            if (dist_valid) begin
              state_q  <= StClear;
              cnt_q    <= '0;
              obstacle <= 1'b0;
              stale    <= 1'b0;
            end
          end
          default: begin
            state_q <= StClear;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_obstacle_filter.sv
// Directed bench for ir_obstacle_filter with hand-computed expectations.
module tb_ir_obstacle_filter;

  localparam int unsigned TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dist_in = 8'd0;
  logic       dist_valid = 1'b0;
  logic [7:0] thr_near = 8'd40;
  logic [7:0] thr_far = 8'd60;
  logic       irq_clr = 1'b0;
  logic [7:0] dist_avg;
  logic       avg_valid;
  logic       obstacle;
  logic       stale;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;

  ir_obstacle_filter #(
    .DEBOUNCE    (3),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .thr_near   (thr_near),
    .thr_far    (thr_far),
    .irq_clr    (irq_clr),
    .dist_avg   (dist_avg),
    .avg_valid  (avg_valid),
    .obstacle   (obstacle),
    .stale      (stale),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    dist_in    = d;
    dist_valid = 1'b1;
    tick();
    dist_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_avg", 32'(dist_avg), 0);
    chk("rst_avg_valid", 32'(avg_valid), 0);
    chk("rst_obstacle", 32'(obstacle), 0);
    chk("rst_stale", 32'(stale), 0);
    chk("rst_irq", 32'(irq), 0);

    // Fill with 100: avg_valid only after the 8th sample
    for (int i = 0; i < 7; i++) begin
      send(8'd100);
      chk("fill_no_avg_valid", 32'(avg_valid), 0);
    end
    send(8'd100);
    chk("fill8_avg_valid", 32'(avg_valid), 1);
    chk("fill8_avg", 32'(dist_avg), 100);
    tick();
    chk("avg_valid_one_cycle", 32'(avg_valid), 0);
    chk("avg_hold", 32'(dist_avg), 100);

    // Samples of 20: averages 90,80,70,60,50,40,30,20
    for (int k = 1; k <= 7; k++) begin
      send(8'd20);
      if (k == 4) chk("avg_after_4x20", 32'(dist_avg), 60);
    end
    send(8'd20);
    chk("avg_after_8x20", 32'(dist_avg), 20);
    chk("obstacle_two_qual", 32'(obstacle), 0);
    tick();
    chk("obstacle_rise", 32'(obstacle), 1);
    chk("irq_on_rise", 32'(irq), 1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_cleared", 32'(irq), 0);
    chk("obstacle_kept", 32'(obstacle), 1);

    // Window becomes 0,100,... (all averages below 60)
    for (int i = 0; i < 4; i++) begin
      send(8'd0);
      send(8'd100);
    end
    chk("avg_setup", 32'(dist_avg), 50);
    // Alternating averages 61/50 must not release
    for (int i = 0; i < 3; i++) begin
      send(8'd90);
      chk("alt_avg_hi", 32'(dist_avg), 61);
      send(8'd10);
      chk("alt_avg_lo", 32'(dist_avg), 50);
    end
    chk("alt_obstacle_held", 32'(obstacle), 1);
    // Averages 81,101,121: release on the third
    send(8'd255);
    send(8'd255);
    send(8'd255);
    chk("avg_121", 32'(dist_avg), 121);
    chk("obstacle_two_far", 32'(obstacle), 1);
    tick();
    chk("obstacle_release", 32'(obstacle), 0);
    chk("no_irq_on_release", 32'(irq), 0);

    // Timeout: one idle cycle already elapsed above
    repeat (TMO - 2) tick();
    chk("stale_not_yet", 32'(stale), 0);
    tick();
    chk("stale_set", 32'(stale), 1);
    chk("stale_obstacle", 32'(obstacle), 1);
    chk("stale_irq", 32'(irq), 1);

    // Recovery: window flushed, refill needs 8 samples
    send(8'd50);
    chk("recover_stale", 32'(stale), 0);
    chk("recover_obstacle", 32'(obstacle), 0);
    chk("recover_no_avg_valid", 32'(avg_valid), 0);
    chk("recover_avg_hold", 32'(dist_avg), 121);
    chk("recover_irq_sticky", 32'(irq), 1);
    for (int i = 0; i < 6; i++) begin
      send(8'd50);
      chk("refill_no_avg_valid", 32'(avg_valid), 0);
    end
    send(8'd50);
    chk("refill_avg_valid", 32'(avg_valid), 1);
    chk("refill_avg", 32'(dist_avg), 50);

    // Reset during the 5th sample of a new burst
    for (int i = 0; i < 4; i++) send(8'd30);
    dist_in    = 8'd30;
    dist_valid = 1'b1;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    dist_valid = 1'b0;
    chk("midrst_avg", 32'(dist_avg), 0);
    chk("midrst_avg_valid", 32'(avg_valid), 0);
    chk("midrst_obstacle", 32'(obstacle), 0);
    chk("midrst_stale", 32'(stale), 0);
    chk("midrst_irq", 32'(irq), 0);
    for (int i = 0; i < 7; i++) begin
      send(8'd80);
      chk("postrst_no_avg_valid", 32'(avg_valid), 0);
    end
    send(8'd80);
    chk("postrst_avg_valid", 32'(avg_valid), 1);
    chk("postrst_avg", 32'(dist_avg), 80);

    // Raise thr_near; irq_clr coincident with the obstacle rise
    thr_near = 8'd90;
    send(8'd80);
    send(8'd80);
    chk("coinc_pre_obstacle", 32'(obstacle), 0);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("coinc_obstacle", 32'(obstacle), 1);
    chk("coinc_irq_set_wins", 32'(irq), 1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("coinc_irq_clr", 32'(irq), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_obstacle_filter.md
IR_OBSTACLE_FILTER -- requirements
Module: ir_obstacle_filter

Interface
REQ-001 Parameter DEBOUNCE, default 3, meaning consecutive qualifying averages needed to change obstacle state (1..15).
REQ-002 Parameter TIMEOUT_CYC, default 131000, meaning clk cycles without dist_valid before stale is declared (fits 20 bits).
REQ-003 Port clk  input  1  system clock; all logic on posedge clk.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port dist_in  input  8  raw distance sample from IR front end; smaller value = nearer.
REQ-006 Port dist_valid  input  1  one-cycle strobe; dist_in is valid in the same cycle.
REQ-007 Port thr_near  input  8  processor-written near threshold.
REQ-008 Port thr_far  input  8  processor-written far/release threshold.
REQ-009 Port irq_clr  input  1  one-cycle strobe clearing irq.
REQ-010 Port dist_avg  output  8  latest 8-sample moving average.
REQ-011 Port avg_valid  output  1  one-cycle strobe when dist_avg updates.
REQ-012 Port obstacle  output  1  debounced obstacle flag.
REQ-013 Port stale  output  1  sensor timeout flag.
REQ-014 Port irq  output  1  sticky interrupt to processor.

Function
REQ-015 Window: 8-entry circular buffer of 8-bit samples plus 3-bit write pointer, 4-bit fill count, 11-bit running sum.
REQ-016 On dist_valid: sum <= sum + dist_in - oldest entry (oldest = 0 while fill < 8); entry overwritten; pointer wraps 7->0; fill saturates at 8.
REQ-017 dist_avg = sum[10:3], registered; avg_valid pulses exactly 1 cycle after the dist_valid cycle, only when fill reached 8 (8th and later samples).
REQ-018 dist_avg holds its value between updates; sum never overflows (max 8*255 = 2040).
REQ-019 FSM states: CLEAR, NEAR_PEND, BLOCKED, FAR_PEND, STALE; evaluated only on avg_valid except timeout.
REQ-020 CLEAR/NEAR_PEND: avg <= thr_near increments debounce count; count reaching DEBOUNCE -> BLOCKED; avg > thr_near -> CLEAR, count 0.
REQ-021 BLOCKED/FAR_PEND: avg >= thr_far increments count; count reaching DEBOUNCE -> CLEAR; avg < thr_far -> BLOCKED, count 0.
REQ-022 Thresholds compared unsigned, sampled at the avg_valid cycle; no correction if thr_far < thr_near.
REQ-023 obstacle = 1 in BLOCKED, FAR_PEND, STALE; 0 otherwise; registered.
REQ-024 Timeout counter clears on dist_valid, else increments; reaching TIMEOUT_CYC from any state -> STALE, stale=1, counter saturates.
REQ-025 STALE: next dist_valid -> CLEAR, stale=0, window flushed (fill 0, sum 0) before that sample is accumulated as first entry.
REQ-026 irq set on obstacle 0->1 transition or STALE entry; cleared by irq_clr; set wins when coincident.

Reset
REQ-027 rst: state CLEAR, counters, pointer, fill, sum and buffer 0; dist_avg=0, avg_valid=0, obstacle=0, stale=0, irq=0.
REQ-028 rst has priority over dist_valid and irq_clr in the same cycle; mid-window reset discards all samples.

Structure
REQ-029 Shared package ir_filter_pkg holds FSM state enum, WIN_DEPTH=8, WIN_LOG2=3, SUM_W=11.
REQ-030 Window/sum logic in sub-module dist_window_avg; FSM, timeout and irq in top.

Verification
REQ-031 Feed 8 samples of 100 -> avg_valid only after 8th, dist_avg=100 one cycle later.
REQ-032 Steady 100 then samples 20, thr_near=40, thr_far=60, DEBOUNCE=3 -> obstacle rises on 3rd avg <=40, irq=1; irq_clr -> irq=0.
REQ-033 From BLOCKED, averages alternating 70/50 -> obstacle stays 1; three consecutive >=60 -> obstacle 0.
REQ-034 Stop dist_valid for TIMEOUT_CYC cycles -> stale=1, obstacle=1, irq=1; next sample -> stale=0, fill restarts, no avg_valid until 8 more.
REQ-035 Assert rst during 5th sample, irq_clr coincident with obstacle rise -> all outputs 0 after rst; irq=1 in coincident case.
